// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing presets and sync polarity constants
package vga_timing_pkg;
  localparam bit POL_LOW = 1'b0;
  localparam bit POL_HIGH = 1'b1;
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP = 16;
  localparam int VGA640_H_SYNC = 96;
  localparam int VGA640_H_BP = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP = 10;
  localparam int VGA640_V_SYNC = 2;
  localparam int VGA640_V_BP = 33;
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP = 56;
  localparam int VGA800_H_SYNC = 120;
  localparam int VGA800_H_BP = 64;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP = 37;
  localparam int VGA800_V_SYNC = 6;
  localparam int VGA800_V_BP = 23;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis counter with wrap, sync window and active-area decode
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP = VGA640_H_FP,
  parameter int SYNC = VGA640_H_SYNC,
  parameter int BP = VGA640_H_BP,
  parameter bit POL = POL_LOW,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          sync,
  output logic          active
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_LO = ACTIVE + FP;
  assign wrap = int'(cnt) == TOTAL - 1;
  assign sync = (int'(cnt) >= SYNC_LO && int'(cnt) < SYNC_LO + SYNC) ? POL : ~POL;
  assign active = int'(cnt) < ACTIVE;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (step) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with registered, mutually aligned outputs
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP = VGA640_H_FP,
  parameter int H_SYNC = VGA640_H_SYNC,
  parameter int H_BP = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP = VGA640_V_FP,
  parameter int V_SYNC = VGA640_V_SYNC,
  parameter int V_BP = VGA640_V_BP,
  parameter bit H_POL = POL_LOW,
  parameter bit V_POL = POL_LOW,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_SYNC == 0 || V_SYNC == 0 || H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end
  logic [CW-1:0] h_cnt, v_cnt;
  logic h_wrap, h_sync, h_act, v_sync, v_act, unused_v_wrap;
  logic h_step;
  assign h_step = pix_ce & en;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CW(CW)) u_h (
    .clk(clk), .rst(rst), .clr(~en), .step(h_step),
    .cnt(h_cnt), .wrap(h_wrap), .sync(h_sync), .active(h_act)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CW(CW)) u_v (
    .clk(clk), .rst(rst), .clr(~en), .step(h_step & h_wrap),
    .cnt(v_cnt), .wrap(unused_v_wrap), .sync(v_sync), .active(v_act)
  );
  // en low is a synchronous return to the reset state, so the next frame restarts cleanly at (0,0)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start <= pix_ce && h_cnt == '0;
      frame_start <= pix_ce && h_cnt == '0 && v_cnt == '0;
      if (pix_ce) begin
        hsync <= h_sync;
        vsync <= v_sync;
        de <= h_act & v_act;
        x <= h_cnt;
        y <= v_cnt;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized pix_ce/en stimulus against a pixel-index raster model for three configurations
module tb_vga_timing_gen;
  import vga_timing_pkg::*;
  logic clk = 1'b0;
  logic rst, pix_ce, en;
  logic [2:0] hs, vs, de_o, ls, fs;
  logic [2:0][10:0] xo, yo;
  int checks = 0, errors = 0;
  int ha[3] = '{640, 10, VGA800_H_ACTIVE};
  int hf[3] = '{16, 2, VGA800_H_FP};
  int hw[3] = '{96, 3, VGA800_H_SYNC};
  int hb[3] = '{48, 2, VGA800_H_BP};
  int va[3] = '{480, 6, VGA800_V_ACTIVE};
  int vf[3] = '{10, 1, VGA800_V_FP};
  int vw[3] = '{2, 2, VGA800_V_SYNC};
  int vb[3] = '{33, 1, VGA800_V_BP};
  bit hp[3] = '{1'b0, 1'b1, 1'b1};
  bit vp[3] = '{1'b0, 1'b1, 1'b1};
  int k[3];
  bit hv[3], els[3], efs[3];
  int cyc = 0, last = -1, nper = 0, de_cnt = 0, ls_cnt = 0;
  bit meas = 0, clean = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .hsync(hs[0]), .vsync(vs[0]), .de(de_o[0]),
    .x(xo[0]), .y(yo[0]), .line_start(ls[0]), .frame_start(fs[0])
  );
  vga_timing_gen #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2),
    .V_BP(1), .H_POL(POL_HIGH), .V_POL(POL_HIGH)) dut1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .hsync(hs[1]), .vsync(vs[1]), .de(de_o[1]),
    .x(xo[1]), .y(yo[1]), .line_start(ls[1]), .frame_start(fs[1])
  );
  vga_timing_gen #(.H_ACTIVE(VGA800_H_ACTIVE), .H_FP(VGA800_H_FP), .H_SYNC(VGA800_H_SYNC), .H_BP(VGA800_H_BP),
    .V_ACTIVE(VGA800_V_ACTIVE), .V_FP(VGA800_V_FP), .V_SYNC(VGA800_V_SYNC), .V_BP(VGA800_V_BP),
    .H_POL(POL_HIGH), .V_POL(POL_HIGH)) dut2 (
    .clk(clk), .rst(rst), .pix_ce(1'b1), .en(en), .hsync(hs[2]), .vsync(vs[2]), .de(de_o[2]),
    .x(xo[2]), .y(yo[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int ht, vt, p, ex, ey;
      bit ehs, evs, ede;
      ht = ha[i] + hf[i] + hw[i] + hb[i];
      vt = va[i] + vf[i] + vw[i] + vb[i];
      p = hv[i] ? k[i] - 1 : 0;
      ex = p % ht;
      ey = (p / ht) % vt;
      ehs = (hv[i] && ex >= ha[i] + hf[i] && ex < ha[i] + hf[i] + hw[i]) ? hp[i] : !hp[i];
      evs = (hv[i] && ey >= va[i] + vf[i] && ey < va[i] + vf[i] + vw[i]) ? vp[i] : !vp[i];
      ede = hv[i] && ex < ha[i] && ey < va[i];
      check($sformatf("x%0d", i), int'(xo[i]), ex);
      check($sformatf("y%0d", i), int'(yo[i]), ey);
      check($sformatf("hsync%0d", i), int'(hs[i]), int'(ehs));
      check($sformatf("vsync%0d", i), int'(vs[i]), int'(evs));
      check($sformatf("de%0d", i), int'(de_o[i]), int'(ede));
      check($sformatf("line_start%0d", i), int'(ls[i]), int'(els[i]));
      check($sformatf("frame_start%0d", i), int'(fs[i]), int'(efs[i]));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      k[i] = 0; hv[i] = 0; els[i] = 0; efs[i] = 0;
    end
    clean = 0;
  endtask

  task automatic tick(input bit ce, input bit e);
    pix_ce = ce;
    en = e;
    @(posedge clk);
    #1;
    cyc++;
    if (rst || !e) clear_model();
    else
      for (int i = 0; i < 3; i++) begin
        int ht, vt;
        ht = ha[i] + hf[i] + hw[i] + hb[i];
        vt = va[i] + vf[i] + vw[i] + vb[i];
        if (i == 2 || ce) begin
          els[i] = k[i] % ht == 0;
          efs[i] = k[i] % (ht * vt) == 0;
          k[i]++;
          hv[i] = 1;
        end else begin
          els[i] = 0; efs[i] = 0;
        end
      end
    check_all();
    if (!rst && e && ce) begin
      if (fs[1]) begin
        if (clean) begin
          check("frame_de_count", de_cnt, 60);
          check("frame_line_count", ls_cnt, 10);
        end
        de_cnt = 0; ls_cnt = 0; clean = 1;
      end
      de_cnt += int'(de_o[1]);
      ls_cnt += int'(ls[1]);
    end
    if (meas && ls[0]) begin
      if (last >= 0) begin
        check("h_period_clk", cyc - last, 3200);
        nper++;
      end
      last = cyc;
    end
  endtask

  initial begin
    int hs0_lo, hs2_hi, hs2_first;
    bit found;
    rst = 1; pix_ce = 0; en = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    hs0_lo = 0; hs2_hi = 0; hs2_first = -1;
    for (int n = 0; n < 2000; n++) begin
      tick(1, 1);
      if (n < 800 && !hs[0]) hs0_lo++;
      if (n < 1040 && hs[2]) begin
        hs2_hi++;
        if (hs2_first < 0) hs2_first = int'(xo[2]);
      end
    end
    check("hsync640_low_width", hs0_lo, 96);
    check("hsync800_high_width", hs2_hi, 120);
    check("hsync800_start_x", hs2_first, 856);
    meas = 1;
    for (int n = 0; n < 7000; n++) tick(n % 4 == 0, 1);
    meas = 0;
    check("h_period_seen", int'(nper >= 1), 1);
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(499) == 0) repeat ($urandom_range(12, 1)) tick(1'($urandom_range(1)), 0);
      tick(1'($urandom_range(1)), 1);
    end
    found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick(1, 1);
      found = xo[0] == 11'd300;
    end
    check("wait_x300", int'(found), 1);
    #2 rst = 1;
    #1 clear_model();
    check_all();
    tick(1, 1);
    rst = 0;
    tick(0, 1);
    tick(1, 1);
    check("frame_start_after_rst", int'(fs[0]), 1);
    found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick(1, 1);
      found = xo[0] == 11'd700;
    end
    check("wait_x700", int'(found), 1);
    repeat (10) tick(1, 0);
    tick(1, 1);
    check("frame_start_after_en", int'(fs[0]), 1);
    check("x_after_en", int'(xo[0]), 0);
    repeat (500) tick(1'($urandom_range(1)), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
